// File: rtl/xpt2046_resp.sv
// XPT2046 touch-controller responder: decodes SPI command bytes and returns
// 12/8-bit samples on MISO. Optional sample jitter is enabled with XPT_JITTER_EN.
module xpt2046_resp #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        tft_tcs,
    input  logic        tft_scl,
    input  logic        tft_mosi,
    output logic        tft_miso,
    output logic        tft_int,
    input  logic [11:0] touch_x,
    input  logic [11:0] touch_y,
    input  logic        touch_press,
    output logic        cmd_done,
    output logic [7:0]  last_cmd,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, BUSY = 2'd2, DATA = 2'd3} state_t;

    logic [SYNC_STAGES-1:0] tcs_q, scl_q, mosi_q;
    logic                   scl_prev;
    logic                   tcs_s, scl_s, mosi_s, scl_rise, scl_fall;

    state_t      state, state_n;
    logic [2:0]  bit_cnt, bit_cnt_n;
    logic [6:0]  cmd_sr, cmd_sr_n;
    logic [3:0]  data_cnt, data_cnt_n;
    logic [11:0] sample, sample_n;
    logic        miso_n, done_n, pen_en, pen_n, int_n;
    logic [7:0]  last_n, cmd_full;
    logic [11:0] raw, snap;
    logic [3:0]  nbits;

    assign tcs_s    = tcs_q[SYNC_STAGES-1];
    assign scl_s    = scl_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_q[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_prev;
    assign scl_fall = ~scl_s & scl_prev;
    assign cmd_full = {cmd_sr, mosi_s};
    assign nbits    = last_cmd[3] ? 4'd8 : 4'd12;
    assign fsm_state = state;

    always_comb begin
        raw = 12'h000;
        case (cmd_full[6:4])
            3'b101:  raw = touch_x;
            3'b001:  raw = touch_y;
            3'b011:  raw = touch_press ? 12'h200 : 12'h000;
            3'b100:  raw = touch_press ? 12'hE00 : 12'hFFF;
            default: raw = 12'h000;
        endcase
    end

`ifdef XPT_JITTER_EN
    logic [15:0] lfsr, lfsr_n;
    logic [12:0] jsum;
    assign jsum = {1'b0, raw} + {11'b0, lfsr[1:0]};
    assign snap = jsum[12] ? 12'hFFF : jsum[11:0];
`else
    assign snap = raw;
`endif

    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        cmd_sr_n   = cmd_sr;
        data_cnt_n = data_cnt;
        sample_n   = sample;
        miso_n     = tft_miso;
        done_n     = 1'b0;
        last_n     = last_cmd;
        pen_n      = pen_en;
`ifdef XPT_JITTER_EN
        lfsr_n     = lfsr;
`endif
        if (tcs_s) begin
            // CS high aborts anything in flight.
            state_n    = IDLE;
            bit_cnt_n  = 3'd0;
            data_cnt_n = 4'd0;
            miso_n     = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_n = CMD;
                    miso_n  = 1'b0;
                end
                CMD: begin
                    if (scl_rise && (bit_cnt != 3'd0 || mosi_s)) begin
                        cmd_sr_n  = cmd_full[6:0];
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            last_n    = cmd_full;
                            done_n    = 1'b1;
                            sample_n  = snap;
                            pen_n     = ~mosi_s;
                            bit_cnt_n = 3'd0;
                            state_n   = BUSY;
`ifdef XPT_JITTER_EN
                            lfsr_n = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
`endif
                        end
                    end
                end
                BUSY: begin
                    if (scl_fall) begin
                        miso_n     = 1'b0;
                        data_cnt_n = 4'd0;
                        state_n    = DATA;
                    end
                end
                DATA: begin
                    if (scl_fall) begin
                        if (data_cnt == nbits) begin
                            miso_n     = 1'b0;
                            data_cnt_n = 4'd0;
                            state_n    = CMD;
                        end else begin
                            miso_n     = sample[4'd11 - data_cnt];
                            data_cnt_n = data_cnt + 4'd1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign int_n = ~(touch_press & tcs_s & pen_en);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tcs_q    <= '1;
            scl_q    <= '0;
            mosi_q   <= '0;
            scl_prev <= 1'b0;
            state    <= IDLE;
            bit_cnt  <= 3'd0;
            cmd_sr   <= 7'd0;
            data_cnt <= 4'd0;
            sample   <= 12'h000;
            tft_miso <= 1'b0;
            tft_int  <= 1'b1;
            cmd_done <= 1'b0;
            last_cmd <= 8'h00;
            pen_en   <= 1'b1;
`ifdef XPT_JITTER_EN
            lfsr     <= 16'hACE1;
`endif
        end else begin
            tcs_q    <= {tcs_q[SYNC_STAGES-2:0], tft_tcs};
            scl_q    <= {scl_q[SYNC_STAGES-2:0], tft_scl};
            mosi_q   <= {mosi_q[SYNC_STAGES-2:0], tft_mosi};
            scl_prev <= scl_s;
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            cmd_sr   <= cmd_sr_n;
            data_cnt <= data_cnt_n;
            sample   <= sample_n;
            tft_miso <= miso_n;
            tft_int  <= int_n;
            cmd_done <= done_n;
            last_cmd <= last_n;
            pen_en   <= pen_n;
`ifdef XPT_JITTER_EN
            lfsr     <= lfsr_n;
`endif
        end
    end

endmodule
